// File: rtl/acc_cpu_core_if.sv
// Instruction handshake bus for acc_cpu_core: the issuer drives master,
// the core takes slave.
interface acc_cpu_core_if #(
  parameter int WIDTH = 4
);
  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand;

  modport master (
    output instr_valid,
    output opcode,
    output operand,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  opcode,
    input  operand,
    output instr_ready
  );
endinterface

// File: rtl/acc_cpu_core.sv
// Three-cycle (IDLE/EXEC/WB) accumulator CPU core.
// Define ACC_CPU_MUL_EN to enable the multiplier on opcode 110; otherwise 110 acts as NOP.
module acc_cpu_core #(
  parameter int WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  acc_cpu_core_if.slave       bus,
  output logic [WIDTH-1:0]    acc,
  output logic [WIDTH-1:0]    out,
  output logic                out_valid,
  output logic                zero,
  output logic                carry,
  output logic [1:0]          current_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    WB      = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_MUL   = 3'b110,
    OP_STORE = 3'b111
  } op_t;

  state_t           state, state_n;
  op_t              op_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q, y_n;
  logic             nc_q, nc_n;
  logic             nz_q;
  logic [WIDTH:0]   sum;
  logic             accept;
  logic             acc_we;

`ifdef ACC_CPU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x_q};
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Ready is masked by reset so an issuer never sees an accept that reset will discard.
  always_comb begin
    state_n         = state;
    accept          = 1'b0;
    bus.instr_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = ~reset;
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC:    state_n = WB;
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, x_q};
    y_n  = '0;
    nc_n = 1'b0;
    case (op_q)
      OP_LOAD: y_n = x_q;
      OP_ADD: begin
        y_n  = sum[WIDTH-1:0];
        nc_n = sum[WIDTH];
      end
      OP_SUB: begin
        y_n  = acc - x_q;
        nc_n = (acc < x_q);
      end
      OP_AND: y_n = acc & x_q;
      OP_OR:  y_n = acc | x_q;
`ifdef ACC_CPU_MUL_EN
      OP_MUL: begin
        y_n  = prod[WIDTH-1:0];
        nc_n = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    acc_we = 1'b0;
    case (op_q)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: acc_we = 1'b1;
`ifdef ACC_CPU_MUL_EN
      OP_MUL: acc_we = 1'b1;
`endif
      default: acc_we = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= OP_NOP;
      x_q  <= '0;
    end else if (accept) begin
      op_q <= op_t'(bus.opcode);
      x_q  <= bus.operand;
    end
  end

  // out_valid self-clears every edge so it can only be high for the cycle after a STORE WB.
  always_ff @(posedge clock) begin
    if (reset) begin
      y_q       <= '0;
      nc_q      <= 1'b0;
      nz_q      <= 1'b1;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b1;
      carry     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == EXEC) begin
        y_q  <= y_n;
        nc_q <= nc_n;
        nz_q <= (y_n == '0);
      end
      if (state == WB) begin
        if (acc_we) begin
          acc   <= y_q;
          zero  <= nz_q;
          carry <= nc_q;
        end
        if (op_q == OP_STORE) begin
          out       <= acc;
          out_valid <= 1'b1;
        end
      end
    end
  end

  assign current_state = state;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core (WIDTH=4): constant vector table,
// hand-written reset corner cases and random instructions against a reference model.
module tb_acc_cpu_core;
  localparam int W = 4;
  localparam int M = 1 << W;
  localparam int NOP = 0, LOAD = 1, ADD = 2, SUB = 3, AND_ = 4, OR_ = 5, MUL = 6, STORE = 7;
  localparam int DROP = 0, HOLD = 1, JUNK = 2;

  logic         clock;
  logic         reset;
  logic [W-1:0] acc, out;
  logic         out_valid, zero, carry;
  logic [1:0]   cur_state;

  acc_cpu_core_if #(.WIDTH(W)) bus ();

  acc_cpu_core #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .acc           (acc),
    .out           (out),
    .out_valid     (out_valid),
    .zero          (zero),
    .carry         (carry),
    .current_state (cur_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int m_acc, m_zero, m_carry, m_out, m_ov;

  typedef struct {
    int op;
    int x;
    int e_acc;
    int e_zero;
    int e_carry;
    int e_out;
    int e_ov;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_zero = 1; m_carry = 0; m_out = 0; m_ov = 0;
  endtask

  // Reference semantics straight from the opcode table with integer arithmetic.
  task automatic model_step(input int op, input int x);
    int r, c;
    bit w;
    r = 0; c = 0; w = 0;
    case (op)
      LOAD: begin r = x; c = 0; w = 1; end
      ADD:  begin r = (m_acc + x) % M; c = ((m_acc + x) >= M); w = 1; end
      SUB:  begin r = (m_acc - x + M) % M; c = (m_acc < x); w = 1; end
      AND_: begin r = m_acc & x; c = 0; w = 1; end
      OR_:  begin r = m_acc | x; c = 0; w = 1; end
`ifdef ACC_CPU_MUL_EN
      MUL:  begin r = (m_acc * x) % M; c = ((m_acc * x) >= M); w = 1; end
`endif
      STORE: m_out = m_acc;
      default: ;
    endcase
    if (w) begin
      m_acc = r; m_zero = (r == 0); m_carry = c;
    end
    m_ov = (op == STORE);
  endtask

  task automatic do_reset();
    bus.instr_valid = 1'b0;
    bus.opcode      = 3'd0;
    bus.operand     = '0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("ready_in_reset", bus.instr_ready, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", bus.instr_ready, 1);
    model_reset();
    @(negedge clock);
  endtask

  task automatic junk_drive();
    bus.instr_valid = 1'($urandom_range(0, 1));
    bus.opcode      = 3'($urandom_range(0, 7));
    bus.operand     = W'($urandom_range(0, M - 1));
  endtask

  // Called at a negedge while IDLE; returns at the negedge after the WB edge.
  task automatic issue(input int op, input int x, input int mode,
                       input int e_acc, input int e_zero, input int e_carry,
                       input int e_out, input int e_ov);
    chk("ready_idle", bus.instr_ready, 1);
    chk("state_idle", cur_state, 0);
    bus.instr_valid = 1'b1;
    bus.opcode      = 3'(op);
    bus.operand     = W'(x);
    @(posedge clock);
    #1;
    if (mode == DROP) bus.instr_valid = 1'b0;
    if (mode == JUNK) junk_drive();
    @(negedge clock);
    chk("state_exec", cur_state, 1);
    chk("ready_exec", bus.instr_ready, 0);
    chk("ov_exec", out_valid, 0);
    @(posedge clock);
    #1;
    if (mode == JUNK) junk_drive();
    @(negedge clock);
    chk("state_wb", cur_state, 2);
    chk("ready_wb", bus.instr_ready, 0);
    chk("ov_wb", out_valid, 0);
    @(posedge clock);
    #1;
    if (mode != HOLD) bus.instr_valid = 1'b0;
    @(negedge clock);
    chk("acc", acc, e_acc);
    chk("zero", zero, e_zero);
    chk("carry", carry, e_carry);
    chk("out", out, e_out);
    chk("out_valid", out_valid, e_ov);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle_ready", bus.instr_ready, 1);
      chk("idle_ov", out_valid, 0);
      chk("idle_acc", acc, m_acc);
      chk("idle_out", out, m_out);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.opcode = 3'd0;
    bus.operand = '0;

    // Hand-derived vectors (acc, zero, carry, out, out_valid after WB)
    tbl.push_back('{LOAD, 5, 5, 0, 0, 0, 0});
    tbl.push_back('{LOAD, 12, 12, 0, 0, 0, 0});
    tbl.push_back('{ADD, 7, 3, 0, 1, 0, 0});
    tbl.push_back('{SUB, 3, 0, 1, 0, 0, 0});
    tbl.push_back('{SUB, 1, 15, 0, 1, 0, 0});
    tbl.push_back('{STORE, 0, 15, 0, 1, 15, 1});
    tbl.push_back('{LOAD, 9, 9, 0, 0, 15, 0});
    tbl.push_back('{STORE, 4, 9, 0, 0, 9, 1});
    tbl.push_back('{LOAD, 2, 2, 0, 0, 9, 0});
    tbl.push_back('{NOP, 7, 2, 0, 0, 9, 0});
    tbl.push_back('{AND_, 3, 2, 0, 0, 9, 0});
    tbl.push_back('{OR_, 5, 7, 0, 0, 9, 0});
    tbl.push_back('{AND_, 8, 0, 1, 0, 9, 0});
    tbl.push_back('{LOAD, 6, 6, 0, 0, 9, 0});
`ifdef ACC_CPU_MUL_EN
    tbl.push_back('{MUL, 3, 2, 0, 1, 9, 0});
    tbl.push_back('{NOP, 0, 2, 0, 1, 9, 0});
`else
    tbl.push_back('{MUL, 3, 6, 0, 0, 9, 0});
    tbl.push_back('{NOP, 0, 6, 0, 0, 9, 0});
`endif

    do_reset();
    chk("rst_state", cur_state, 0);
    chk("rst_acc", acc, 0);
    chk("rst_out", out, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_zero", zero, 1);
    chk("rst_carry", carry, 0);

    foreach (tbl[i]) begin
      model_step(tbl[i].op, tbl[i].x);
      issue(tbl[i].op, tbl[i].x, DROP, tbl[i].e_acc, tbl[i].e_zero,
            tbl[i].e_carry, tbl[i].e_out, tbl[i].e_ov);
      idle(i % 2);
    end

    // Back-to-back ADD 1 with instr_valid held: accept every third cycle, wrap at 16
    do_reset();
    for (int i = 1; i <= 17; i++)
      issue(ADD, 1, HOLD, i % M, (i % M) == 0, i == 16, 0, 0);
    bus.instr_valid = 1'b0;
    @(negedge clock);

    // Reset during WB aborts the LOAD
    do_reset();
    issue(LOAD, 3, DROP, 3, 0, 0, 0, 0);
    bus.instr_valid = 1'b1; bus.opcode = 3'(LOAD); bus.operand = W'(6);
    @(posedge clock); #1; bus.instr_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("abort_wb_state", cur_state, 2);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_wb_acc", acc, 0);
    chk("abort_wb_zero", zero, 1);
    chk("abort_wb_st", cur_state, 0);
    chk("abort_wb_ready", bus.instr_ready, 0);
    reset = 1'b0;
    model_reset();
    #1;
    chk("abort_wb_ready1", bus.instr_ready, 1);
    @(negedge clock);
    issue(NOP, 0, DROP, 0, 1, 0, 0, 0);

    // Reset during EXEC of a STORE: no out write, no pulse
    do_reset();
    issue(LOAD, 9, DROP, 9, 0, 0, 0, 0);
    bus.instr_valid = 1'b1; bus.opcode = 3'(STORE); bus.operand = '0;
    @(posedge clock); #1; bus.instr_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ex_state", cur_state, 0);
    @(negedge clock);
    chk("abort_ex_out", out, 0);
    chk("abort_ex_ov", out_valid, 0);
    chk("abort_ex_acc", acc, 0);
    model_reset();

    // Reset wins over a simultaneous accept
    bus.instr_valid = 1'b1; bus.opcode = 3'(LOAD); bus.operand = W'(5);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_vs_accept_state", cur_state, 0);
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    idle(2);

    // Random instructions with busy-time junk on the bus and idle gaps
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int op, x;
      op = int'($urandom_range(0, 7));
      x  = int'($urandom_range(0, M - 1));
      model_step(op, x);
      issue(op, x, JUNK, m_acc, m_zero, m_carry, m_out, m_ov);
      idle(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 Parameter WIDTH, default 4, datapath width in bits; legal range 2..32.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr_ready  output  1  core can accept an instruction; high only in IDLE.
REQ-006 opcode  input  3  operation select, sampled on accept.
REQ-007 operand  input  WIDTH  X operand, sampled on accept.
REQ-008 acc  output  WIDTH  accumulator value.
REQ-009 out  output  WIDTH  Z output register, written by STORE only.
REQ-010 out_valid  output  1  one-cycle pulse when out is written.
REQ-011 zero  output  1  last ALU result equals 0.
REQ-012 carry  output  1  carry/borrow/overflow of last ALU op.
REQ-013 current_state  output  2  FSM state encoding: IDLE=0, EXEC=1, WB=2.

Function
REQ-014 Opcodes SHALL be: 000 NOP, 001 LOAD (Y=X), 010 ADD (Y=acc+X), 011 SUB (Y=acc-X), 100 AND, 101 OR, 110 MUL (optional, see REQ-031), 111 STORE.
REQ-015 Accept SHALL occur on an edge where state=IDLE and instr_valid=1; the edge latches opcode/operand and moves to EXEC.
REQ-016 instr_valid while instr_ready=0 SHALL be ignored; no queuing.
REQ-017 EXEC edge SHALL register ALU result into Y (WIDTH bits), next-carry and next-zero, and move to WB.
REQ-018 WB edge SHALL: for 001..110 write acc<=Y, zero<=(Y==0), carry<=next-carry; for NOP and STORE leave acc, zero, carry unchanged; move to IDLE.
REQ-019 STORE WB edge SHALL write out<=acc and set out_valid=1 for exactly the following cycle; out holds otherwise.
REQ-020 Latency: acc visible 3 edges after accept edge counted inclusive (accept, EXEC, WB); throughput one instruction per 3 cycles.
REQ-021 ADD carry SHALL be bit WIDTH of the (WIDTH+1)-bit sum; results wrap modulo 2^WIDTH.
REQ-022 SUB carry SHALL be 1 when acc < X (borrow), result wraps modulo 2^WIDTH.
REQ-023 LOAD, AND, OR SHALL set carry=0.
REQ-024 Unreachable current_state value 3 SHALL transition to IDLE on the next edge with no register writes.
REQ-025 out_valid SHALL be 0 in every cycle not immediately following a STORE WB edge.

Reset
REQ-026 reset=1 at an edge SHALL override every other condition including an accept.
REQ-027 Reset values: state=IDLE, acc=0, out=0, out_valid=0, zero=1, carry=0, X=0, Y=0.
REQ-028 Reset asserted during EXEC or WB SHALL abort the instruction; no acc/out/flag update from it.
REQ-029 instr_ready SHALL be 0 in any cycle where reset=1 and 1 in the first cycle after reset deasserts.

Configuration
REQ-030 Macro ACC_CPU_MUL_EN SHALL control the multiplier.
REQ-031 Defined: opcode 110 SHALL compute Y=low WIDTH bits of acc*X, carry=1 when high WIDTH bits nonzero.
REQ-032 Undefined: opcode 110 SHALL behave exactly as NOP (acc, zero, carry unchanged; still 3 cycles) and no multiplier logic is instantiated.

Verification (WIDTH=4)
REQ-033 Reset, then LOAD 5 -> acc=5 three edges after accept, zero=0, carry=0, out_valid never high.
REQ-034 LOAD 12, ADD 7 -> acc=3, carry=1, zero=0; SUB 3 -> acc=0, zero=1, carry=0; SUB 1 -> acc=15, carry=1.
REQ-035 LOAD 9, STORE -> out=9 with out_valid high one cycle; then LOAD 2 -> out stays 9, out_valid 0.
REQ-036 instr_valid held high continuously with ADD 1 from acc=0 -> instr_ready high every third cycle, acc steps 1,2,3,... ; wraps 15->0 with carry=1.
REQ-037 LOAD 6 accepted, reset asserted during WB -> acc=0, zero=1, state IDLE next cycle.
REQ-038 LOAD 6, opcode 110 operand 3 -> with ACC_CPU_MUL_EN acc=2, carry=1; without, acc=6, flags unchanged.
